// File: rtl/mixer_nch.sv
`default_nettype none
// ============================================================================
//  Module      : mixer_nch
//  Description : N-channel stereo mixer. Each channel latches its latest
//                sample; a trigger snapshots all latches and per-channel
//                L/R gains, then a one-channel-per-cycle MAC sums the
//                channels, the sums are scaled by 1/128, saturated to SW
//                bits and presented with one-cycle ready strobes.
//  Ports       : clk, reset (async, active high)
//                midi_rdy/midi_cmd/midi_ch_sysn/midi_data0/midi_data1 :
//                  MIDI CC gain writes (CC14 -> gain_l, CC15 -> gain_r)
//                smpl_in_rdy[NCH], smpl_in[NCH*SW] : per-channel samples
//                smpl_rate_trig : starts one mix frame
//                smpl_out_rdy_l/_r, smpl_out_l/_r : mixed results
//                clip : last frame saturated, err_overrun : sticky overrun
//  Revision    : 1.0 - initial release
// ============================================================================

`ifndef MIDI_CMD_SIZE
`define MIDI_CMD_SIZE 4
`endif
`ifndef MIDI_CMD_CC
`define MIDI_CMD_CC 4'd3
`endif

module mixer_nch #(
  parameter int NCH = 4,
  parameter int SW  = 18
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      midi_rdy,
  input  logic [`MIDI_CMD_SIZE-1:0] midi_cmd,
  input  logic [3:0]                midi_ch_sysn,
  input  logic [6:0]                midi_data0,
  input  logic [6:0]                midi_data1,
  input  logic [NCH-1:0]            smpl_in_rdy,
  input  logic [NCH*SW-1:0]         smpl_in,
  input  logic                      smpl_rate_trig,
  output logic                      smpl_out_rdy_l,
  output logic                      smpl_out_rdy_r,
  output logic signed [SW-1:0]      smpl_out_l,
  output logic signed [SW-1:0]      smpl_out_r,
  output logic                      clip,
  output logic                      err_overrun
);

  localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int PW = SW + 8;
  localparam int AW = PW + $clog2(NCH);

  // Saturation bounds expressed at accumulator width
  localparam logic signed [AW-1:0] SMAX = {{(AW-SW+1){1'b0}}, {(SW-1){1'b1}}};
  localparam logic signed [AW-1:0] SMIN = {{(AW-SW+1){1'b1}}, {(SW-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_MAC, S_SAT, S_OUT} state_t;

  state_t state;

  logic signed [SW-1:0] lat      [NCH];
  logic signed [SW-1:0] lat_nxt  [NCH];
  logic signed [SW-1:0] snap     [NCH];
  logic [6:0]           gain_l   [NCH];
  logic [6:0]           gain_r   [NCH];
  logic [6:0]           gl_nxt   [NCH];
  logic [6:0]           gr_nxt   [NCH];
  logic [6:0]           snap_gl  [NCH];
  logic [6:0]           snap_gr  [NCH];

  logic [CW-1:0]        ch;
  logic signed [AW-1:0] acc_l, acc_r;
  logic signed [PW-1:0] prod_l, prod_r;
  logic signed [AW-1:0] sh_l, sh_r;
  logic signed [SW-1:0] sat_l, sat_r;
  logic                 clip_l, clip_r;
  logic                 cc_ok, wr_l, wr_r;

  // Next-state values for latches and gains; the snapshot reads these so a
  // write landing in the trigger cycle is included in that frame.
  always_comb begin
    cc_ok = midi_rdy && (midi_cmd == `MIDI_CMD_CC) && (32'(midi_ch_sysn) < NCH);
    wr_l  = cc_ok && (midi_data0 == 7'd14);
    wr_r  = cc_ok && (midi_data0 == 7'd15);
    for (int k = 0; k < NCH; k++) begin
      lat_nxt[k] = smpl_in_rdy[k] ? smpl_in[k*SW +: SW] : lat[k];
      gl_nxt[k]  = (wr_l && (midi_ch_sysn == 4'(k))) ? midi_data1 : gain_l[k];
      gr_nxt[k]  = (wr_r && (midi_ch_sysn == 4'(k))) ? midi_data1 : gain_r[k];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < NCH; k++) begin
        lat[k]    <= '0;
        gain_l[k] <= 7'd127;
        gain_r[k] <= 7'd127;
      end
    end else begin
      for (int k = 0; k < NCH; k++) begin
        lat[k]    <= lat_nxt[k];
        gain_l[k] <= gl_nxt[k];
        gain_r[k] <= gr_nxt[k];
      end
    end
  end

  // Gains are zero-extended so they act as unsigned 0..127 multipliers
  always_comb begin
    prod_l = PW'(snap[ch]) * PW'($signed({1'b0, snap_gl[ch]}));
    prod_r = PW'(snap[ch]) * PW'($signed({1'b0, snap_gr[ch]}));
  end

  // Arithmetic shift floors toward minus infinity before clamping
  always_comb begin
    sh_l   = acc_l >>> 7;
    sh_r   = acc_r >>> 7;
    clip_l = 1'b0;
    clip_r = 1'b0;
    sat_l  = sh_l[SW-1:0];
    sat_r  = sh_r[SW-1:0];
    if (sh_l > SMAX) begin
      sat_l  = SMAX[SW-1:0];
      clip_l = 1'b1;
    end else if (sh_l < SMIN) begin
      sat_l  = SMIN[SW-1:0];
      clip_l = 1'b1;
    end
    if (sh_r > SMAX) begin
      sat_r  = SMAX[SW-1:0];
      clip_r = 1'b1;
    end else if (sh_r < SMIN) begin
      sat_r  = SMIN[SW-1:0];
      clip_r = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= S_IDLE;
      ch             <= '0;
      acc_l          <= '0;
      acc_r          <= '0;
      smpl_out_rdy_l <= 1'b0;
      smpl_out_rdy_r <= 1'b0;
      smpl_out_l     <= '0;
      smpl_out_r     <= '0;
      clip           <= 1'b0;
      err_overrun    <= 1'b0;
      for (int k = 0; k < NCH; k++) begin
        snap[k]    <= '0;
        snap_gl[k] <= '0;
        snap_gr[k] <= '0;
      end
    end else begin
      smpl_out_rdy_l <= 1'b0;
      smpl_out_rdy_r <= 1'b0;
      if (smpl_rate_trig && (state != S_IDLE)) begin
        err_overrun <= 1'b1;
      end
      case (state)
        S_IDLE: begin
          if (smpl_rate_trig) begin
            for (int k = 0; k < NCH; k++) begin
              snap[k]    <= lat_nxt[k];
              snap_gl[k] <= gl_nxt[k];
              snap_gr[k] <= gr_nxt[k];
            end
            acc_l <= '0;
            acc_r <= '0;
            ch    <= '0;
            state <= S_MAC;
          end
        end
        S_MAC: begin
          acc_l <= acc_l + AW'(prod_l);
          acc_r <= acc_r + AW'(prod_r);
          if (ch == CW'(NCH - 1)) begin
            state <= S_SAT;
          end else begin
            ch <= ch + CW'(1);
          end
        end
        S_SAT: begin
          smpl_out_l     <= sat_l;
          smpl_out_r     <= sat_r;
          clip           <= clip_l | clip_r;
          smpl_out_rdy_l <= 1'b1;
          smpl_out_rdy_r <= 1'b1;
          state          <= S_OUT;
        end
        S_OUT: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mixer_nch.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mixer_nch
//  Description : Self-checking bench for mixer_nch (NCH=4, SW=18). Expected
//                frame results are queued at trigger time and compared when
//                the output strobes fire.
//  Revision    : 1.0 - initial release
// ============================================================================

`ifndef MIDI_CMD_SIZE
`define MIDI_CMD_SIZE 4
`endif
`ifndef MIDI_CMD_CC
`define MIDI_CMD_CC 4'd3
`endif

module tb_mixer_nch;

  localparam int NCH = 4;
  localparam int SW  = 18;

  logic                      clk = 1'b0;
  logic                      reset;
  logic                      midi_rdy;
  logic [`MIDI_CMD_SIZE-1:0] midi_cmd;
  logic [3:0]                midi_ch_sysn;
  logic [6:0]                midi_data0;
  logic [6:0]                midi_data1;
  logic [NCH-1:0]            smpl_in_rdy;
  logic [NCH*SW-1:0]         smpl_in;
  logic                      smpl_rate_trig;
  logic                      smpl_out_rdy_l, smpl_out_rdy_r;
  logic signed [SW-1:0]      smpl_out_l, smpl_out_r;
  logic                      clip, err_overrun;

  mixer_nch #(.NCH(NCH), .SW(SW)) dut (
    .clk(clk), .reset(reset),
    .midi_rdy(midi_rdy), .midi_cmd(midi_cmd), .midi_ch_sysn(midi_ch_sysn),
    .midi_data0(midi_data0), .midi_data1(midi_data1),
    .smpl_in_rdy(smpl_in_rdy), .smpl_in(smpl_in),
    .smpl_rate_trig(smpl_rate_trig),
    .smpl_out_rdy_l(smpl_out_rdy_l), .smpl_out_rdy_r(smpl_out_rdy_r),
    .smpl_out_l(smpl_out_l), .smpl_out_r(smpl_out_r),
    .clip(clip), .err_overrun(err_overrun)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic signed [SW-1:0] l;
    logic signed [SW-1:0] r;
    logic                 c;
  } exp_t;

  exp_t q[$];
  int   tests   = 0;
  int   fails   = 0;
  int   strobes = 0;
  logic [`MIDI_CMD_SIZE-1:0] cc_cmd;

  // Scoreboard: every strobe must match the oldest queued expectation
  always @(negedge clk) begin
    if (smpl_out_rdy_l || smpl_out_rdy_r) begin
      exp_t e;
      strobes++;
      tests++;
      if (smpl_out_rdy_l !== smpl_out_rdy_r) begin
        fails++;
        $display("FAIL rdy_coincident: l=%0b r=%0b required equal", smpl_out_rdy_l, smpl_out_rdy_r);
      end
      tests++;
      if (q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_strobe: got strobe, required none (L=%0d R=%0d)", smpl_out_l, smpl_out_r);
      end else begin
        e = q.pop_front();
        if (smpl_out_l !== e.l) begin
          fails++;
          $display("FAIL out_l: got %0d required %0d", smpl_out_l, e.l);
        end
        tests++;
        if (smpl_out_r !== e.r) begin
          fails++;
          $display("FAIL out_r: got %0d required %0d", smpl_out_r, e.r);
        end
        tests++;
        if (clip !== e.c) begin
          fails++;
          $display("FAIL clip: got %0b required %0b", clip, e.c);
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    smpl_rate_trig = 1'b0;
    smpl_in_rdy    = '0;
    midi_rdy       = 1'b0;
  endtask

  task automatic put_smpl(input int k, input int v);
    smpl_in[k*SW +: SW] = SW'(v);
    smpl_in_rdy[k]      = 1'b1;
    tick();
    clear_inputs();
  endtask

  task automatic put_all(input int v);
    for (int k = 0; k < NCH; k++) smpl_in[k*SW +: SW] = SW'(v);
    smpl_in_rdy = '1;
    tick();
    clear_inputs();
  endtask

  task automatic cc(input logic [`MIDI_CMD_SIZE-1:0] cmd, input int mch,
                    input int num, input int val);
    midi_cmd     = cmd;
    midi_ch_sysn = 4'(mch);
    midi_data0   = 7'(num);
    midi_data1   = 7'(val);
    midi_rdy     = 1'b1;
    tick();
    clear_inputs();
  endtask

  // Called in cycle n after the trigger; waits for the strobe, checks that
  // it lands in cycle T+6, then steps into the following IDLE cycle.
  task automatic wait_out(input int n0);
    int n = n0;
    while (!smpl_out_rdy_l && n < 14) begin
      tick();
      n++;
    end
    tests++;
    if (n != NCH + 2) begin
      fails++;
      $display("FAIL latency: strobe at T+%0d required T+%0d", n, NCH + 2);
    end
    tick();
  endtask

  // Inputs already set by the caller are applied together with the trigger
  task automatic fire(input int el, input int er, input logic ec);
    q.push_back('{l: SW'(el), r: SW'(er), c: ec});
    smpl_rate_trig = 1'b1;
    tick();
    clear_inputs();
    wait_out(1);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    clear_inputs();
    smpl_in = '0;
    midi_cmd = '0; midi_ch_sysn = '0; midi_data0 = '0; midi_data1 = '0;
    repeat (3) tick();
    reset = 1'b0;
    tests++;
    if ({smpl_out_rdy_l, smpl_out_rdy_r, smpl_out_l, smpl_out_r, clip, err_overrun} !== '0) begin
      fails++;
      $display("FAIL reset_outputs: got L=%0d R=%0d clip=%0b ovr=%0b required all 0",
               smpl_out_l, smpl_out_r, clip, err_overrun);
    end
    fire(0, 0, 1'b0);
  endtask

  task automatic test_unity();
    put_smpl(0, 1000);
    fire(992, 992, 1'b0);
    put_smpl(0, -1000);
    fire(-993, -993, 1'b0);
    repeat (3) tick();
    tests++;
    if (smpl_out_l !== -18'sd993) begin
      fails++;
      $display("FAIL out_hold: got %0d required -993", smpl_out_l);
    end
  endtask

  task automatic test_cc_routing();
    put_smpl(0, 0);
    cc(cc_cmd, 1, 14, 0);
    put_smpl(1, 5000);
    fire(0, 4960, 1'b0);
    // Out-of-range channels, foreign CC numbers and non-CC commands
    cc(cc_cmd, 7, 15, 0);
    cc(cc_cmd, 5, 15, 0);
    cc(cc_cmd, 1, 20, 0);
    cc(cc_cmd ^ `MIDI_CMD_SIZE'(1), 1, 15, 0);
    fire(0, 4960, 1'b0);
    cc(cc_cmd, 1, 14, 127);
    fire(4960, 4960, 1'b0);
  endtask

  task automatic test_saturation();
    put_all(131071);
    fire(131071, 131071, 1'b1);
    put_all(-131072);
    fire(-131072, -131072, 1'b1);
    put_all(0);
    fire(0, 0, 1'b0);
  endtask

  task automatic test_overrun();
    int s0 = strobes;
    put_smpl(0, 1000);
    q.push_back('{l: SW'(992), r: SW'(992), c: 1'b0});
    smpl_rate_trig = 1'b1;
    tick();                // T+1
    clear_inputs();
    tick();                // T+2
    tick();                // T+3
    smpl_rate_trig = 1'b1;
    tick();                // T+4
    clear_inputs();
    wait_out(4);
    repeat (NCH + 4) tick();
    tests++;
    if (strobes != s0 + 1) begin
      fails++;
      $display("FAIL overrun_strobes: got %0d strobes required 1", strobes - s0);
    end
    tests++;
    if (err_overrun !== 1'b1) begin
      fails++;
      $display("FAIL err_overrun_set: got %0b required 1", err_overrun);
    end
  endtask

  task automatic test_coincidence();
    put_smpl(0, 0);
    // Sample write in the trigger cycle is part of the frame
    smpl_in[2*SW +: SW] = SW'(2000);
    smpl_in_rdy[2]      = 1'b1;
    fire(1984, 1984, 1'b0);
    // Sample write two cycles after the trigger is not
    put_smpl(2, 0);
    q.push_back('{l: SW'(0), r: SW'(0), c: 1'b0});
    smpl_rate_trig = 1'b1;
    tick();                // T+1
    clear_inputs();
    tick();                // T+2
    smpl_in[2*SW +: SW] = SW'(2000);
    smpl_in_rdy[2]      = 1'b1;
    tick();                // T+3
    clear_inputs();
    wait_out(3);
    fire(1984, 1984, 1'b0);
    // Gain write in the trigger cycle is part of the frame
    put_smpl(2, 0);
    put_smpl(0, 1000);
    midi_cmd = cc_cmd; midi_ch_sysn = 4'd0; midi_data0 = 7'd14; midi_data1 = 7'd64;
    midi_rdy = 1'b1;
    fire(500, 992, 1'b0);
    tests++;
    if (err_overrun !== 1'b1) begin
      fails++;
      $display("FAIL err_overrun_sticky: got %0b required 1", err_overrun);
    end
  endtask

  task automatic test_reset_midframe();
    int s0 = strobes;
    smpl_rate_trig = 1'b1;
    tick();                // T+1
    clear_inputs();
    tick();                // T+2
    tick();                // T+3
    reset = 1'b1;
    #1;
    tests++;
    if ({smpl_out_l, smpl_out_r, clip, err_overrun, smpl_out_rdy_l} !== '0) begin
      fails++;
      $display("FAIL midframe_reset_outputs: got L=%0d R=%0d clip=%0b ovr=%0b required 0",
               smpl_out_l, smpl_out_r, clip, err_overrun);
    end
    tick();
    reset = 1'b0;
    repeat (NCH + 4) tick();
    tests++;
    if (strobes != s0) begin
      fails++;
      $display("FAIL aborted_frame_strobe: got %0d strobes required 0", strobes - s0);
    end
    // Gains are back to 127 and latches back to 0
    put_smpl(0, 1000);
    fire(992, 992, 1'b0);
  endtask

  initial begin
    cc_cmd = `MIDI_CMD_CC;
    test_reset();
    test_unity();
    test_cc_routing();
    test_saturation();
    test_overrun();
    test_coincidence();
    test_reset_midframe();
    repeat (4) tick();
    tests++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL missing_strobes: got %0d frames pending required 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
